// File: rtl/branch_ctrl_unit_pkg.sv
// Shared definitions for the execute-stage branch control unit:
// PNZ flag bit positions, reset value and the condition-match helper.
package branch_ctrl_unit_pkg;

  localparam int FLAG_P = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  localparam logic [2:0] PNZ_RST = 3'b000;

  // A conditional branch is taken when any requested PNZ bit is set.
  function automatic logic pnz_match(input logic [2:0] cond, input logic [2:0] flags);
    return |(cond & flags);
  endfunction

endpackage

// File: rtl/branch_ctrl_unit_ret_addr_stack.sv
// Circular return-address LIFO; a push while full silently replaces the oldest
// entry so the most recent DEPTH return addresses are always retained.
module ret_addr_stack #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [ADDR_W-1:0]          push_addr,
  output logic [ADDR_W-1:0]          top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr_inc;
  logic [CNT_W-1:0]  cnt;

  // wr_ptr always points at the slot the next push lands in; top sits one behind.
  assign rd_ptr     = (wr_ptr == '0) ? PTR_W'(DEPTH-1) : wr_ptr - PTR_W'(1);
  assign wr_ptr_inc = (wr_ptr == PTR_W'(DEPTH-1)) ? '0 : wr_ptr + PTR_W'(1);

  assign top   = mem[rd_ptr];
  assign count = cnt;
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr_inc;
      if (!full) cnt <= cnt + CNT_W'(1);
    end else if (pop && !empty) begin
      wr_ptr <= rd_ptr;
      cnt    <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_addr;
  end

endmodule

// File: rtl/branch_ctrl_unit.sv
// Execute-stage redirect control: conditional branches on registered PNZ flags,
// subroutine call/return through a circular RAS, and nested interrupt entry/exit.
module branch_ctrl_unit
  import branch_ctrl_unit_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int RAS_DEPTH = 8,
  parameter int INT_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           stall,
  input  logic [ADDR_W-1:0]              pc_in,
  input  logic [ADDR_W-1:0]              alu_target,
  input  logic                           br,
  input  logic [2:0]                     br_cond,
  input  logic                           call,
  input  logic                           ret,
  input  logic                           flags_we,
  input  logic [2:0]                     flags_new,
  input  logic                           int_req,
  input  logic [ADDR_W-1:0]              int_vec,
  input  logic                           err_clr,
  output logic [ADDR_W-1:0]              branch_addr,
  output logic                           branch_taken,
  output logic                           int_ack,
  output logic [$clog2(INT_DEPTH+1)-1:0] int_level,
  output logic [2:0]                     flags_out,
  output logic                           ras_ovf,
  output logic                           ras_unf
);

  localparam int LVL_W = $clog2(INT_DEPTH+1);
  localparam int IDX_W = (INT_DEPTH > 1) ? $clog2(INT_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH+1);

  logic [2:0]        flags_q;
  logic [LVL_W-1:0]  level_q;
  logic [LVL_W-1:0]  level_dec;
  logic [ADDR_W+2:0] int_stack [INT_DEPTH];
  logic [ADDR_W+2:0] saved_ctx;

  logic              int_accept, ret_int, ret_sub;
  logic              ras_push, ras_pop, ras_full, ras_empty;
  logic [ADDR_W-1:0] ras_top;
  logic [CNT_W-1:0]  ras_count;

  assign level_dec = level_q - LVL_W'(1);
  assign saved_ctx = int_stack[level_dec[IDX_W-1:0]];

  // A return in flight blocks interrupt entry so the pop and push never collide.
  assign int_accept = !stall && int_req && !ret && (level_q < LVL_W'(INT_DEPTH));
  assign ret_int    = !stall && ret && (level_q != '0);
  assign ret_sub    = !stall && ret && (level_q == '0);
  assign ras_push   = !stall && call && !ret && !int_accept;
  assign ras_pop    = ret_sub && !ras_empty;

  always_comb begin
    branch_addr  = '0;
    branch_taken = 1'b0;
    int_ack      = 1'b0;
    if (int_accept) begin
      branch_addr  = int_vec;
      branch_taken = 1'b1;
      int_ack      = 1'b1;
    end else if (ret_int) begin
      branch_addr  = saved_ctx[ADDR_W+2:3];
      branch_taken = 1'b1;
    end else if (ret_sub) begin
      branch_addr  = (ras_count == '0) ? '0 : ras_top;
      branch_taken = 1'b1;
    end else if (!stall && br) begin
      branch_addr  = alu_target;
      branch_taken = pnz_match(br_cond, flags_q);
    end
  end

  ret_addr_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_addr (pc_in + ADDR_W'(1)),
    .top       (ras_top),
    .count     (ras_count),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= PNZ_RST;
      level_q <= '0;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else if (!stall) begin
      if (int_accept) begin
        level_q <= level_q + LVL_W'(1);
      end else if (ret_int) begin
        level_q <= level_dec;
        flags_q <= saved_ctx[2:0];
      end else if (flags_we) begin
        flags_q <= flags_new;
      end
      // Clear first so a same-cycle error event still leaves its flag set.
      if (err_clr) begin
        ras_ovf <= 1'b0;
        ras_unf <= 1'b0;
      end
      if (ras_push && ras_full) ras_ovf <= 1'b1;
      if (ret_sub && ras_empty) ras_unf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (int_accept) int_stack[level_q[IDX_W-1:0]] <= {pc_in, flags_q};
  end

  assign int_level = level_q;
  assign flags_out = flags_q;

endmodule
